// File: rtl/sram_ctrl_pkg.sv
// Shared constants for the external asynchronous SRAM controller.
// Request direction encoding and default geometry live here.
package sram_ctrl_pkg;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam int DEFAULT_ADDR_BITS = 10;
  localparam int DEFAULT_DATA_BITS = 8;

endpackage

// File: rtl/sram_io_buf.sv
// Tri-state pad buffer for the SRAM data pins: registered drive enable and
// output data, plus an input-capture register (the SB_IO registered modes on iCE40).
module sram_io_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             drive_next,
  input  logic [WIDTH-1:0] dout_next,
  input  logic             capture_en,
  output logic [WIDTH-1:0] din,
  inout  wire  [WIDTH-1:0] pad
);

  logic             drive_reg;
  logic [WIDTH-1:0] dout_reg;
  logic [WIDTH-1:0] din_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      drive_reg <= 1'b0;
      dout_reg  <= '0;
      din_reg   <= '0;
    end else begin
      drive_reg <= drive_next;
      dout_reg  <= dout_next;
      if (capture_en) begin
        din_reg <= pad;
      end
    end
  end

  assign pad = drive_reg ? dout_reg : {WIDTH{1'bz}};
  assign din = din_reg;

endmodule

// File: rtl/sram_ctrl.sv
// Single-port async SRAM controller: one registered access per clock, read data
// two edges after the address. Optional SRAM_CTRL_WE_PULSE_EN gates WE# with clk_i.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 rw_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic [ADDR_BITS-1:0] addr_bus_o,
  output logic                 we_n_o,
  output logic                 oe_n_o,
  inout  wire  [DATA_BITS-1:0] data_bus_io,
  output logic                 ce_n_o
);

  logic [ADDR_BITS-1:0] addr_reg;
  logic                 we_reg;
  logic                 oe_reg;
  logic                 ce_reg;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_reg <= '0;
      we_reg   <= 1'b1;
      oe_reg   <= 1'b1;
      ce_reg   <= 1'b1;
    end else begin
      addr_reg <= addr_i;
      we_reg   <= (rw_i == RW_WRITE) ? 1'b0 : 1'b1;
      oe_reg   <= (rw_i == RW_READ)  ? 1'b0 : 1'b1;
      ce_reg   <= 1'b0;
    end
  end

  // Capture happens on the edge after a read address was placed (OE# low).
  sram_io_buf #(
    .WIDTH (DATA_BITS)
  ) u_io_buf (
    .clk        (clk_i),
    .srst       (reset_i),
    .drive_next (rw_i == RW_WRITE),
    .dout_next  (data_i),
    .capture_en (~oe_reg),
    .din        (data_o),
    .pad        (data_bus_io)
  );

  assign addr_bus_o = addr_reg;
  assign oe_n_o     = oe_reg;
  assign ce_n_o     = ce_reg;

`ifdef SRAM_CTRL_WE_PULSE_EN
  // WE# only falls in the low half-cycle, after the address has settled.
  assign we_n_o = we_reg | clk_i;
`else
  assign we_n_o = we_reg;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl with a behavioural async SRAM on the pins
// and a request-level reference model of memory contents and read data.
module tb_sram_ctrl;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          rw_i = 1'b1;
  logic [AW-1:0] addr_i = '0;
  logic [DW-1:0] data_i = '0;
  logic [DW-1:0] data_o;
  logic [AW-1:0] addr_bus_o;
  logic          we_n_o, oe_n_o, ce_n_o;
  wire  [DW-1:0] data_bus_io;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_ctrl #(.ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .rw_i        (rw_i),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .data_o      (data_o),
    .addr_bus_o  (addr_bus_o),
    .we_n_o      (we_n_o),
    .oe_n_o      (oe_n_o),
    .data_bus_io (data_bus_io),
    .ce_n_o      (ce_n_o)
  );

  // Behavioural asynchronous SRAM: drives on read, stores mid-cycle on write.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign data_bus_io = (!ce_n_o && !oe_n_o && we_n_o) ? mem[addr_bus_o] : {DW{1'bz}};

  always @(negedge clk) begin
    #1;
    if (!ce_n_o && !we_n_o) mem[addr_bus_o] = data_bus_io;
  end

  // Reference model state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_data_o = '0;
  logic          pend_valid = 1'b0;
  logic [DW-1:0] pend_val = '0;
  logic [DW-1:0] zz = {DW{1'bz}};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One request per clock; checks the pins and data_o just after the edge.
  task automatic step(input logic rst, input logic rw, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    reset_i = rst;
    rw_i    = rw;
    addr_i  = a;
    data_i  = d;
    @(posedge clk);
    #1;
    if (pend_valid) exp_data_o = pend_val;
    pend_valid = 1'b0;
    if (rst) begin
      exp_data_o = '0;
    end else if (rw) begin
      pend_val   = ref_mem[a];
      pend_valid = 1'b1;
    end else begin
      ref_mem[a] = d;
    end
    chk("data_o", {24'b0, data_o}, {24'b0, exp_data_o});
    chk("ce_n", {31'b0, ce_n_o}, {31'b0, rst});
    chk("oe_n", {31'b0, oe_n_o}, {31'b0, rst | ~rw});
    chk("addr_bus", {22'b0, addr_bus_o}, rst ? 32'd0 : {22'b0, a});
`ifndef SRAM_CTRL_WE_PULSE_EN
    chk("we_n", {31'b0, we_n_o}, {31'b0, rst | rw});
`endif
    if (rst)     chk("bus_z", {24'b0, data_bus_io}, {24'b0, zz});
    else if (rw) chk("bus_rd", {24'b0, data_bus_io}, {24'b0, ref_mem[a]});
    else         chk("bus_wr", {24'b0, data_bus_io}, {24'b0, d});
    $display("t=%0t rst=%0b rw=%0b addr=%h din=%h -> data_o=%h we_n=%0b oe_n=%0b bus=%h",
             $time, rst, rw, a, d, data_o, we_n_o, oe_n_o, data_bus_io);
  endtask

  task automatic check_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < (1 << AW); i++) if (mem[i] !== ref_mem[i]) bad++;
    chk(tag, bad, 0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = DW'(i * 7 + 3);
      ref_mem[i] = DW'(i * 7 + 3);
    end

    // Reset held for two clocks
    step(1'b1, 1'b0, 10'h155, 8'h77);
    step(1'b1, 1'b0, 10'h2AA, 8'h88);
`ifndef SRAM_CTRL_WE_PULSE_EN
    chk("reset_we_n", {31'b0, we_n_o}, 32'd1);
`endif

    // Release with an idle read
    step(1'b0, 1'b1, 10'h000, 8'h00);

    // Burst write
    step(1'b0, 1'b0, 10'h100, 8'hA1);
    step(1'b0, 1'b0, 10'h101, 8'hB2);
    step(1'b0, 1'b0, 10'h102, 8'hC3);

    // Turnaround then pipelined reads
    step(1'b0, 1'b1, 10'h000, 8'h00);
    step(1'b0, 1'b1, 10'h100, 8'h00);
    step(1'b0, 1'b1, 10'h101, 8'h00);
    chk("burst_rd0", {24'b0, data_o}, 32'hA1);
    step(1'b0, 1'b1, 10'h102, 8'h00);
    chk("burst_rd1", {24'b0, data_o}, 32'hB2);
    step(1'b0, 1'b1, 10'h000, 8'h00);
    chk("burst_rd2", {24'b0, data_o}, 32'hC3);
    check_mem("mem_after_burst");

    // Randomized traffic over a small address window to force reuse
    for (int n = 0; n < 300; n++) begin
      logic rw;
      rw = ($urandom_range(0, 2) != 0);
      step(1'b0, rw, AW'($urandom_range(0, 31)), DW'($urandom));
    end
    step(1'b0, 1'b1, 10'h000, 8'h00);
    check_mem("mem_after_random");

    // Reset in the middle of a write burst
    step(1'b0, 1'b0, 10'h200, 8'h11);
    step(1'b0, 1'b0, 10'h201, 8'h22);
    step(1'b1, 1'b0, 10'h202, 8'h33);
`ifndef SRAM_CTRL_WE_PULSE_EN
    chk("midrst_we_n", {31'b0, we_n_o}, 32'd1);
`endif
    step(1'b1, 1'b0, 10'h203, 8'h44);
    check_mem("mem_after_midrst");
    step(1'b0, 1'b1, 10'h202, 8'h00);
    step(1'b0, 1'b1, 10'h201, 8'h00);
    chk("midrst_untouched", {24'b0, data_o}, {24'b0, ref_mem[10'h202]});

`ifdef SRAM_CTRL_WE_PULSE_EN
    // Write then read immediately with no turnaround gap
    step(1'b0, 1'b0, 10'h3FF, 8'h5A);
    step(1'b0, 1'b1, 10'h3FF, 8'h00);
    step(1'b0, 1'b1, 10'h000, 8'h00);
    chk("pulse_rd", {24'b0, data_o}, 32'h5A);
    check_mem("pulse_mem");
`endif

    step(1'b0, 1'b1, 10'h000, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
